button_conditioner: RTL and testbench

Conditions the two raw steering push-buttons before they reach the `Input` steering stage. Each button is synchronised into `CLK`, debounced with a consecutive-stable-cycle counter, and edge-detected into a one-cycle press pulse. Each press is held as a pending flag until the downstream stage acknowledges its sample tick, so a press shorter than the roughly 6 Hz steering sample interval is never lost. The `leftButton`/`rightButton` outputs connect directly to the `Input` ports of the same name.

---
 rtl/button_conditioner.sv | 102 ++++++++++
 tb/tb_button_conditioner.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Synchronise, debounce and edge-detect two steering buttons, holding each press until acked.
// Level/pulse rise DEBOUNCE_CYCLES+2 edges after a stable press, pending one edge later; no backpressure.

module button_conditioner_chan #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  input  logic i_ack,
  output logic o_level,
  output logic o_pulse,
  output logic o_pend
);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_pulse;
  logic             r_pend;
  logic             w_differ;
  logic             w_commit;

  assign w_differ = (r_s2 != r_level);
  assign w_commit = w_differ && (r_cnt == LP_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      // Any return of s2 to the current level restarts the stability count.
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_commit) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_pulse <= w_commit && r_s2;
      // A new press on the ack edge must survive, so set dominates clear.
      r_pend  <= (r_pend && !i_ack) || r_pulse;
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;
  assign o_pend  = r_pend;
endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic CLK,
  input  logic RST,
  input  logic leftButtonRaw,
  input  logic rightButtonRaw,
  input  logic ack,
  output logic leftButton,
  output logic rightButton,
  output logic leftLevel,
  output logic rightLevel,
  output logic leftPulse,
  output logic rightPulse
);
  button_conditioner_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_left (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_raw  (leftButtonRaw),
    .i_ack  (ack),
    .o_level(leftLevel),
    .o_pulse(leftPulse),
    .o_pend (leftButton)
  );

  button_conditioner_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_right (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_raw  (rightButtonRaw),
    .i_ack  (ack),
    .o_level(rightLevel),
    .o_pulse(rightPulse),
    .o_pend (rightButton)
  );
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4.
module tb_button_conditioner;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic leftButtonRaw = 1'b0;
  logic rightButtonRaw = 1'b0;
  logic ack = 1'b0;
  logic leftButton, rightButton, leftLevel, rightLevel, leftPulse, rightPulse;

  int errors = 0;
  int checks = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .leftButtonRaw (leftButtonRaw),
    .rightButtonRaw(rightButtonRaw),
    .ack           (ack),
    .leftButton    (leftButton),
    .rightButton   (rightButton),
    .leftLevel     (leftLevel),
    .rightLevel    (rightLevel),
    .leftPulse     (leftPulse),
    .rightPulse    (rightPulse)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1 time unit after each edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [31:0] outs();
    return {26'd0, leftButton, rightButton, leftLevel, rightLevel, leftPulse, rightPulse};
  endfunction

  task automatic pulse_ack();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  initial begin
    int npulse;

    // 1: reset with both buttons held, then re-debounce after release
    leftButtonRaw = 1'b1;
    rightButtonRaw = 1'b1;
    RST = 1'b1;
    step(2);
    chk("reset_all_zero", outs(), 32'd0);
    RST = 1'b0;
    step(5);
    chk("rst_rel_level_early", 32'(leftLevel), 32'd0);
    step(1);
    chk("rst_rel_level_6", 32'(leftLevel), 32'd1);
    chk("rst_rel_pulse_6", 32'(leftPulse), 32'd1);
    chk("rst_rel_pend_6", 32'(leftButton), 32'd0);
    step(1);
    chk("rst_rel_pend_7", 32'(leftButton), 32'd1);
    chk("rst_rel_pulse_7", 32'(leftPulse), 32'd0);
    chk("rst_rel_right_pend", 32'(rightButton), 32'd1);
    leftButtonRaw = 1'b0;
    rightButtonRaw = 1'b0;
    step(5);
    chk("release_level_early", 32'(leftLevel), 32'd1);
    step(1);
    chk("release_level_6", 32'(leftLevel), 32'd0);
    chk("release_pend_held", 32'(leftButton), 32'd1);
    pulse_ack();
    chk("ack_clears_both", outs(), 32'd0);

    // 2: single-cycle glitch restarts the count
    npulse = 0;
    for (int i = 1; i <= 14; i++) begin
      leftButtonRaw = (i == 4) ? 1'b0 : 1'b1;
      step(1);
      if (i == 6) chk("bounce_no_early_level", 32'(leftLevel), 32'd0);
      if (i == 9) chk("bounce_level_e9", 32'(leftLevel), 32'd0);
      if (i == 10) chk("bounce_level_e10", 32'(leftLevel), 32'd1);
      npulse += int'(leftPulse);
    end
    chk("bounce_pulse_count", 32'(npulse), 32'd1);
    chk("bounce_pend", 32'(leftButton), 32'd1);
    pulse_ack();
    chk("bounce_ack", 32'(leftButton), 32'd0);
    leftButtonRaw = 1'b0;
    step(8);
    chk("bounce_released", outs(), 32'd0);

    // 3: short press is latched until acked
    leftButtonRaw = 1'b1;
    step(8);
    leftButtonRaw = 1'b0;
    step(20);
    chk("short_press_held", 32'(leftButton), 32'd1);
    chk("short_press_level_low", 32'(leftLevel), 32'd0);
    pulse_ack();
    chk("short_press_ack", 32'(leftButton), 32'd0);
    step(5);
    chk("short_press_stays_clear", 32'(leftButton), 32'd0);

    // 4: ack coincident with a new pulse while already pending keeps the flag set
    rightButtonRaw = 1'b1;
    step(8);
    rightButtonRaw = 1'b0;
    step(8);
    chk("setwins_pre_pend", 32'(rightButton), 32'd1);
    rightButtonRaw = 1'b1;
    step(6);
    chk("setwins_pulse", 32'(rightPulse), 32'd1);
    pulse_ack();
    chk("setwins_pend_kept", 32'(rightButton), 32'd1);
    step(3);
    pulse_ack();
    chk("setwins_lone_ack", 32'(rightButton), 32'd0);
    rightButtonRaw = 1'b0;
    step(8);
    chk("setwins_released", outs(), 32'd0);

    // 5: both buttons pressed together
    leftButtonRaw = 1'b1;
    rightButtonRaw = 1'b1;
    step(6);
    chk("both_pulses", outs(), 32'b001111);
    step(1);
    chk("both_pending", outs(), 32'b111100);
    pulse_ack();
    chk("both_acked", outs(), 32'b001100);
    leftButtonRaw = 1'b0;
    rightButtonRaw = 1'b0;
    step(8);

    // 6: reset mid-count with a pending press
    rightButtonRaw = 1'b1;
    step(8);
    rightButtonRaw = 1'b0;
    step(8);
    chk("midrst_pre_pend", 32'(rightButton), 32'd1);
    rightButtonRaw = 1'b1;
    step(4);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    chk("midrst_all_zero", outs(), 32'd0);
    step(5);
    chk("midrst_no_early_pulse", 32'(rightPulse), 32'd0);
    step(1);
    chk("midrst_pulse_6", 32'(rightPulse), 32'd1);
    step(1);
    chk("midrst_pend_7", 32'(rightButton), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
